// File: rtl/fpu_mult_arb_pkg.sv
// Shared types and constants for the bfloat16 multiplier arbiter.
package fpu_mult_arb_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_QNAN = 16'h7FC0;
  localparam bf16_t BF16_ZERO = 16'h0000;
  localparam int    STAT_W    = 16;

endpackage

// File: rtl/Mult.sv
// Combinational bfloat16 multiplier: round-to-nearest-even, subnormals flushed
// to zero, canonical quiet NaN for NaN inputs and inf*0.
module Mult
  import fpu_mult_arb_pkg::*;
(
  input  bf16_t a_i,
  input  bf16_t b_i,
  output bf16_t result_o
);

  logic              sign;
  logic [7:0]        ea, eb;
  logic [6:0]        ma, mb, man;
  logic [15:0]       prod;
  logic signed [9:0] exp_s;
  logic              guard, sticky, rnd;
  logic [7:0]        man_r;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  always_comb begin
    sign   = a_i[15] ^ b_i[15];
    ea     = a_i[14:7];
    eb     = b_i[14:7];
    ma     = a_i[6:0];
    mb     = b_i[6:0];
    nan_a  = (ea == 8'hFF) && (ma != 7'd0);
    nan_b  = (eb == 8'hFF) && (mb != 7'd0);
    inf_a  = (ea == 8'hFF) && (ma == 7'd0);
    inf_b  = (eb == 8'hFF) && (mb == 7'd0);
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);

    prod  = 16'({1'b1, ma}) * 16'({1'b1, mb});
    exp_s = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // Product of two 1.x significands lies in [1,4); normalise on the top bit.
    if (prod[15]) begin
      man    = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      man    = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
    end

    rnd   = guard & (sticky | man[0]);
    man_r = {1'b0, man} + {7'd0, rnd};
    if (man_r[7]) begin
      exp_s = exp_s + 10'sd1;
    end

    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      result_o = BF16_QNAN;
    end else if (inf_a || inf_b) begin
      result_o = {sign, 8'hFF, 7'd0};
    end else if (zero_a || zero_b) begin
      result_o = {sign, 15'd0};
    end else if (exp_s >= 10'sd255) begin
      result_o = {sign, 8'hFF, 7'd0};
    end else if (exp_s <= 10'sd0) begin
      result_o = {sign, 15'd0};
    end else begin
      result_o = {sign, exp_s[7:0], man_r[6:0]};
    end
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i,
// wrapping modulo NUM_REQ.
module fpu_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_i} + (ID_W+1)'(off);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (en_i && !found && req_i[cand[ID_W-1:0]]) begin
        found                     = 1'b1;
        grant_o[cand[ID_W-1:0]]   = 1'b1;
        idx_o                     = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_mult_arbiter.sv
// Shares one bf16 multiplier among NUM_REQ requesters with a one-entry result
// stage. Optional per-requester grant counters under FPU_MULT_ARB_STATS_EN.
module fpu_mult_arbiter
  import fpu_mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  bf16_t [NUM_REQ-1:0]   req_a_i,
  input  bf16_t [NUM_REQ-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output bf16_t                 rsp_result_o,
  output logic                  busy_o
`ifdef FPU_MULT_ARB_STATS_EN
  ,
  input  logic                             stat_clr_i,
  output logic [NUM_REQ-1:0][STAT_W-1:0]   stat_grants_o
`endif
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    ptr_reg, owner_reg, grant_idx, ptr_next;
  logic               full_reg;
  bf16_t              result_reg, prod;
  logic [NUM_REQ-1:0] grant;
  logic               stage_free, arb_en, accept;

  // Drain and refill may happen in the same cycle.
  assign stage_free = !full_reg || rsp_ready_i[owner_reg];
  assign arb_en     = stage_free && rst_ni;

  fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_reg),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign accept      = |grant;
  assign req_ready_o = grant;
  assign ptr_next    = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  Mult u_mult (
    .a_i      (req_a_i[grant_idx]),
    .b_i      (req_b_i[grant_idx]),
    .result_o (prod)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg    <= '0;
      owner_reg  <= '0;
      full_reg   <= 1'b0;
      result_reg <= BF16_ZERO;
    end else if (accept) begin
      result_reg <= prod;
      owner_reg  <= grant_idx;
      ptr_reg    <= ptr_next;
      full_reg   <= 1'b1;
    end else if (stage_free) begin
      full_reg   <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (full_reg) begin
      rsp_valid_o[owner_reg] = 1'b1;
    end
  end

  assign rsp_result_o = result_reg;
  assign busy_o       = full_reg;

`ifdef FPU_MULT_ARB_STATS_EN
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_reg;

    // A grant coinciding with a clear restarts the count at one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg <= '0;
      end else if (stat_clr_i) begin
        cnt_reg <= grant[gi] ? STAT_W'(1) : '0;
      end else if (grant[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign stat_grants_o[gi] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Scoreboard bench for fpu_mult_arbiter; counter checks run only when
// FPU_MULT_ARB_STATS_EN is defined.
module tb_fpu_mult_arbiter;

  localparam int NUM_REQ = 4;

  typedef struct {
    int          id;
    logic [15:0] res;
  } sb_entry_t;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic [NUM_REQ-1:0]        req_valid_i = '0;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0][15:0]  req_a_i = '0;
  logic [NUM_REQ-1:0][15:0]  req_b_i = '0;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [NUM_REQ-1:0]        rsp_ready_i = '1;
  logic [15:0]               rsp_result_o;
  logic                      busy_o;
`ifdef FPU_MULT_ARB_STATS_EN
  logic                      stat_clr_i = 1'b0;
  logic [NUM_REQ-1:0][15:0]  stat_grants_o;
`endif

  logic [15:0] exp_r [NUM_REQ];
  sb_entry_t   sb_q[$];
  int          grant_log[$];
  int          n_cmp = 0;
  int          n_err = 0;

  fpu_mult_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o)
`ifdef FPU_MULT_ARB_STATS_EN
    ,
    .stat_clr_i    (stat_clr_i),
    .stat_grants_o (stat_grants_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e);
    req_a_i[i] = a;
    req_b_i[i] = b;
    exp_r[i]   = e;
  endtask

  // Responses are retired before new accepts are queued in the same cycle.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
          end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            $display("rsp id=%0d result=%h", i, rsp_result_o);
            check("rsp_id", 32'(i), 32'(e.id));
            check("rsp_data", 32'(rsp_result_o), 32'(e.res));
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          sb_q.push_back('{id: i, res: exp_r[i]});
          grant_log.push_back(i);
        end
      end
    end
  end

  initial begin
    int exp_rr[6];
    int exp_13[3];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_13 = '{3, 1, 3};
    for (int i = 0; i < NUM_REQ; i++) exp_r[i] = '0;

    // Reset state, including ready gating while in reset
    req_valid_i = 4'b1111;
    #12;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_result", 32'(rsp_result_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    req_valid_i = '0;
    step();
    rst_ni = 1'b1;
    step();

    // Single request on req 0
    set_op(0, 16'h3F80, 16'h4000, 16'h4000);
    req_valid_i = 4'b0001;
    #1;
    check("single_ready", 32'(req_ready_o), 32'h1);
    step();
    req_valid_i = '0;
    check("single_valid", 32'(rsp_valid_o), 32'h1);
    check("single_result", 32'(rsp_result_o), 32'h4000);
    check("single_busy", 32'(busy_o), 32'd1);
    step();
    check("drain_valid", 32'(rsp_valid_o), 32'd0);
    check("drain_hold", 32'(rsp_result_o), 32'h4000);
    check("drain_busy", 32'(busy_o), 32'd0);

    // Back-to-back on req 2, one result per cycle
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_op(2, 16'h3FC0, 16'h3FC0, 16'h4010);
        1: set_op(2, 16'hC000, 16'h4040, 16'hC0C0);
        default: set_op(2, 16'h7F80, 16'h0000, 16'h7FC0);
      endcase
      req_valid_i = 4'b0100;
      #1;
      check("b2b_ready", 32'(req_ready_o), 32'h4);
      step();
      check("b2b_valid", 32'(rsp_valid_o), 32'h4);
    end
    req_valid_i = '0;
    step();

    // Move the pointer to 0 with a grant to req 3
    set_op(3, 16'h4000, 16'h4000, 16'h4080);
    req_valid_i = 4'b1000;
    step();
    req_valid_i = '0;
    step();

    // Round robin across all four, then only 1 and 3 from pointer 2
    set_op(0, 16'h4000, 16'h4000, 16'h4080);
    set_op(1, 16'h4040, 16'h4040, 16'h4110);
    set_op(2, 16'h3F00, 16'h4080, 16'h4000);
    set_op(3, 16'hBF80, 16'hBF80, 16'h3F80);
    grant_log.delete();
    req_valid_i = 4'b1111;
    repeat (6) step();
    req_valid_i = '0;
    check("rr_len", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check("rr_order", 32'(grant_log[k]), 32'(exp_rr[k]));
    grant_log.delete();
    req_valid_i = 4'b1010;
    repeat (3) step();
    req_valid_i = '0;
    check("rr13_len", 32'(grant_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < grant_log.size(); k++)
      check("rr13_order", 32'(grant_log[k]), 32'(exp_13[k]));
    step();

    // Backpressure on owner 1; other rsp_ready bits high and ignored
    set_op(1, 16'h3FA0, 16'h3FA0, 16'h3FC8);
    req_valid_i = 4'b0010;
    step();
    req_valid_i = 4'b0001;
    rsp_ready_i = 4'b1101;
    set_op(0, 16'h7FC1, 16'h3F80, 16'h7FC0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 32'(req_ready_o), 32'd0);
      check("bp_valid", 32'(rsp_valid_o), 32'h2);
      check("bp_result", 32'(rsp_result_o), 32'h3FC8);
      step();
    end
    rsp_ready_i = 4'b1111;
    #1;
    check("bp_drain_grant", 32'(req_ready_o), 32'h1);
    step();
    req_valid_i = '0;
    check("bp_next_valid", 32'(rsp_valid_o), 32'h1);
    step();

    // Asynchronous reset with a pending result on req 2
    set_op(2, 16'h4040, 16'h0000, 16'h0000);
    rsp_ready_i = 4'b1011;
    req_valid_i = 4'b0100;
    step();
    req_valid_i = '0;
    check("pre_rst_valid", 32'(rsp_valid_o), 32'h4);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(rsp_valid_o), 32'd0);
    check("arst_result", 32'(rsp_result_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    step();
    rst_ni = 1'b1;
    rsp_ready_i = 4'b1111;
    set_op(1, 16'hC040, 16'h4000, 16'hC0C0);
    req_valid_i = 4'b1010;
    #1;
    check("post_rst_grant", 32'(req_ready_o), 32'h2);
    step();
    req_valid_i = '0;
    check("post_rst_valid", 32'(rsp_valid_o), 32'h2);
    step();

`ifdef FPU_MULT_ARB_STATS_EN
    // Grant counters
    req_valid_i = 4'b1000;
    repeat (5) step();
    req_valid_i = '0;
    check("stat3_five", 32'(stat_grants_o[3]), 32'd5);
    check("stat1_one", 32'(stat_grants_o[1]), 32'd1);
    stat_clr_i = 1'b1;
    req_valid_i = 4'b1000;
    step();
    stat_clr_i = 1'b0;
    req_valid_i = '0;
    check("stat_clr_grant", 32'(stat_grants_o[3]), 32'd1);
    check("stat_clr_other", 32'(stat_grants_o[1]), 32'd0);
    step();
    force dut.g_stat[3].cnt_reg = 16'hFFFF;
    step();
    release dut.g_stat[3].cnt_reg;
    req_valid_i = 4'b1000;
    step();
    req_valid_i = '0;
    check("stat_saturate", 32'(stat_grants_o[3]), 32'hFFFF);
    step();
`endif

    repeat (2) step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_mult_arbiter.md
Name: fpu_mult_arbiter

Overview:
- Shares one bfloat16 multiplier (`Mult`, combinational) among NUM_REQ requesters, e.g. ALU lanes and a dot-product sequencer.
- Round-robin arbitration on valid/ready request channels.
- Registers the product in a single result stage and returns it to the granted requester over a per-requester valid/ready response channel.
- Sits between the FPU issue logic and the multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the owner index (derived; not to be overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester operand valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ x 16  bf16 operand A per requester.
- req_b_i  in  NUM_REQ x 16  bf16 operand B per requester.
- rsp_valid_o  out  NUM_REQ  result valid; one-hot or zero, asserted only to the owner.
- rsp_ready_i  in  NUM_REQ  per-requester result accept.
- rsp_result_o  out  16  bf16 product; shared bus, meaningful only where rsp_valid_o is set.
- busy_o  out  1  result stage occupied.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values:
  - rsp_valid_o = 0, rsp_result_o = 16'h0000, busy_o = 0.
  - Round-robin pointer = 0, owner index = 0.
  - req_ready_o = 0 while rst_ni is low.
- Result stage is free when it is empty, or when it is full and rsp_ready_i[owner] = 1 this cycle (drain and refill in the same cycle is allowed).
- Grant: when the stage is free, grant the first i with req_valid_i[i] = 1, searching from the pointer upward with wrap-around modulo NUM_REQ.
  - req_ready_o[i] = 1 for that i only, same cycle.
  - req_ready_o may depend combinationally on req_valid_i. req_valid_i must not depend on req_ready_o.
- Accept (req_valid_i[i] && req_ready_o[i]) at edge N:
  - Register product Mult(req_a_i[i], req_b_i[i]) into rsp_result_o.
  - Set owner = i and pointer = (i+1) mod NUM_REQ.
  - rsp_valid_o[i] = 1 after edge N, i.e. 1-cycle latency.
- Pointer changes only on an accepted grant. Idle cycles leave it unchanged.
- Response hold: while rsp_valid_o[owner] = 1 and rsp_ready_i[owner] = 0, rsp_result_o and the owner are stable and no grant is issued.
- Drain without a new accept: rsp_valid_o returns to 0 and rsp_result_o keeps its last value.
- Throughput: one product per cycle when the owner holds rsp_ready_i high.
- rsp_ready_i of non-owners is ignored.
- Requesters hold their operands stable while valid && !ready. Dropping valid before accept is legal; that requester is simply not granted.
- Edge-case results come from `Mult` unchanged, including canonical NaN 16'h7FC0 for NaN inputs or inf*0.
- Reset asserted mid-operation: a pending result is discarded with no response; pointer returns to 0.
- busy_o = OR of rsp_valid_o.

Optional Feature:
- Macro: FPU_MULT_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants_o, NUM_REQ x 16.
  - Per-requester count of accepted grants, saturating at 16'hFFFF, reset to 0.
  - Adds input stat_clr_i, 1 bit. When set, synchronously zeroes all counters. A grant in the same cycle as a clear counts as 1.
- Not defined: no ports, no counters.

Decomposition:
- Package fpu_mult_arb_pkg:
  - typedef bf16_t (logic [15:0]).
  - Constants BF16_QNAN = 16'h7FC0 and BF16_ZERO = 16'h0000.
  - Stat counter width STAT_W = 16.
- One sub-module, fpu_rr_arbiter: parameterised NUM_REQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index; purely combinational.
- The top holds the pointer, result stage and handshakes, and instantiates `Mult` once.

Test Plan:
- Single request, A=16'h3F80 (1.0), B=16'h4000 (2.0) on req 0, rsp_ready high.
  - req_ready_o[0] in the same cycle.
  - Next cycle rsp_valid_o = 4'b0001, rsp_result_o = 16'h4000.
- Three back-to-back products on req 2, rsp_ready high, accepts on consecutive cycles:
  - 16'h3FC0 * 16'h3FC0 -> 16'h4010.
  - 16'hC000 * 16'h4040 -> 16'hC0C0.
  - 16'h7F80 * 16'h0000 -> 16'h7FC0.
  - Expect one result per cycle.
- All four requesters valid continuously, rsp_ready high: grant order 0,1,2,3,0,1 and the pointer wraps. Then only req 1 and req 3 valid, starting with the pointer at 2: grant order 3,1,3.
- Backpressure: result owned by req 1, rsp_ready_i[1] low for 3 cycles while req 0 is valid.
  - rsp_result_o stable and req_ready_o = 0 for those cycles.
  - Drain cycle grants req 0; its result appears the next cycle.
- Assert rst_ni low while rsp_valid_o[2] = 1: outputs go to 0 asynchronously; after release the first grant goes to the lowest valid index from pointer 0.
- With FPU_MULT_ARB_STATS_EN defined:
  - 5 grants to req 3 -> stat_grants_o[3] = 5.
  - stat_clr_i together with a grant -> 1.
  - Forcing a counter to 16'hFFFF and granting again -> stays 16'hFFFF.
